tdc_hit_sequencer: RTL and testbench

- Sequences one TDC conversion per hit: latches the 175-tap delay-line snapshot and the coarse count, locates the thermometer edge, and encodes it to a binary fine index.
- Presents {coarse, fine, err} on a valid/ready interface to the readout.
- Enforces a programmable dead time and counts hits dropped while busy.
- Sits between the sampled delay-line flops and the readout FIFO.

---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_edge_encode.sv | 33 +++
 rtl/tdc_hit_sequencer.sv | 160 ++++++++++++++++
 tb/tb_tdc_hit_sequencer.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared constants, state encoding and edge-check helper for the TDC hit
// sequencer and its edge encoder.
package tdc_pkg;

    localparam int NTAPS    = 175;
    localparam int FINE_W   = 8;
    localparam int COARSE_W = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EDGE = 3'd1,
        ENC  = 3'd2,
        OUT  = 3'd3,
        DEAD = 3'd4
    } tdc_seq_state_t;

    // A valid one-hot edge vector has exactly one bit set: flag none or several.
    function automatic logic edge_err(input logic [NTAPS-1:0] v);
        logic [NTAPS-1:0] v_m1;
        v_m1 = v - {{(NTAPS-1){1'b0}}, 1'b1};
        return (v == {NTAPS{1'b0}}) || ((v & v_m1) != {NTAPS{1'b0}});
    endfunction

endpackage

// File: rtl/tdc_edge_encode.sv
// Combinational thermometer edge logic.
//   snap : latched delay-line snapshot  -> oh   : one-hot edge vector
//   oh_q : registered one-hot edge vector -> fine : OR-encoded index,
//                                            err  : no edge or bubble
// The two halves are split so the sequencer can place its EDGE/ENC
// pipeline registers between them.
module tdc_edge_encode
    import tdc_pkg::*;
(
    input  logic [NTAPS-1:0]  snap,
    input  logic [NTAPS-1:0]  oh_q,
    output logic [NTAPS-1:0]  oh,
    output logic [FINE_W-1:0] fine,
    output logic              err
);

    // Edge detect: the top tap has no neighbour above, so shifting in a zero
    // makes oh[NTAPS-1] equal to snap[NTAPS-1].
    always_comb begin
        oh = snap & ~(snap >> 1);
    end

    // OR-encoder: flat OR of all set indices, no priority chain. A bubble
    // therefore yields the OR of its edge indices, flagged through err.
    always_comb begin
        fine = {FINE_W{1'b0}};
        for (int i = 0; i < NTAPS; i++) begin
            fine = fine | (oh_q[i] ? FINE_W'(i) : {FINE_W{1'b0}});
        end
        err = edge_err(oh_q);
    end

endmodule

// File: rtl/tdc_hit_sequencer.sv
// One TDC conversion per hit: latch snapshot and coarse count, find the
// thermometer edge, encode it and hand {coarse, fine, err} to the readout
// over valid/ready, then hold off for a dead time.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   enable            run control (coarse counter and hit acceptance)
//   hit, taps         hit pulse and same-cycle delay-line sample
//   ts_valid/ts_ready readout handshake
//   ts_coarse/ts_fine/ts_err  timestamp payload
//   busy              state is not IDLE
//   drop_cnt/drop_clr saturating dropped-hit counter and its clear
module tdc_hit_sequencer
    import tdc_pkg::*;
#(
    parameter int DEAD_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                hit,
    input  logic [NTAPS-1:0]    taps,
    output logic                ts_valid,
    input  logic                ts_ready,
    output logic [COARSE_W-1:0] ts_coarse,
    output logic [FINE_W-1:0]   ts_fine,
    output logic                ts_err,
    output logic                busy,
    output logic [7:0]          drop_cnt,
    input  logic                drop_clr
);

    tdc_seq_state_t      state_r, state_s;
    logic [COARSE_W-1:0] coarse_r;
    logic [NTAPS-1:0]    snap_r, oh_r, oh_s;
    logic [FINE_W-1:0]   fine_s, ts_fine_r;
    logic                err_s, ts_err_r, ts_valid_r, busy_r;
    logic [COARSE_W-1:0] ts_coarse_r;
    logic [7:0]          drop_cnt_r, dead_cnt_r;
    logic                accept_s, drop_s, handshake_s;

    tdc_edge_encode u_enc (
        .snap (snap_r),
        .oh_q (oh_r),
        .oh   (oh_s),
        .fine (fine_s),
        .err  (err_s)
    );

    // Next-state decode plus hit accept/drop qualification.
    always_comb begin
        state_s     = state_r;
        accept_s    = hit & enable & (state_r == IDLE);
        drop_s      = hit & enable & (state_r != IDLE);
        handshake_s = (state_r == OUT) & ts_ready;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = EDGE;
                end else begin
                    state_s = IDLE;
                end
            end
            EDGE: state_s = ENC;
            ENC:  state_s = OUT;
            OUT: begin
                if (ts_ready) begin
                    state_s = DEAD;
                end else begin
                    state_s = OUT;
                end
            end
            DEAD: begin
                // Count value 1 is the last DEAD cycle; it decrements to 0 on exit.
                if (dead_cnt_r <= 8'd1) begin
                    state_s = IDLE;
                end else begin
                    state_s = DEAD;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, busy and valid flags derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            ts_valid_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            busy_r     <= (state_s != IDLE);
            ts_valid_r <= (state_s == OUT);
        end
    end

    // Free-running coarse counter, cleared whenever enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse_r <= {COARSE_W{1'b0}};
        end else if (enable) begin
            coarse_r <= coarse_r + {{(COARSE_W-1){1'b0}}, 1'b1};
        end else begin
            coarse_r <= {COARSE_W{1'b0}};
        end
    end

    // Conversion pipeline: snapshot at hit, one-hot in EDGE, encode in ENC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_r      <= {NTAPS{1'b0}};
            oh_r        <= {NTAPS{1'b0}};
            ts_coarse_r <= {COARSE_W{1'b0}};
            ts_fine_r   <= {FINE_W{1'b0}};
            ts_err_r    <= 1'b0;
        end else begin
            if (accept_s) begin
                snap_r      <= taps;
                ts_coarse_r <= coarse_r;
            end
            if (state_r == EDGE) begin
                oh_r <= oh_s;
            end
            if (state_r == ENC) begin
                ts_fine_r <= fine_s;
                ts_err_r  <= err_s;
            end
        end
    end

    // Dead-time counter: loaded on the handshake, counts down in DEAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dead_cnt_r <= 8'd0;
        end else if (handshake_s) begin
            dead_cnt_r <= 8'(DEAD_CYC);
        end else if ((state_r == DEAD) && (dead_cnt_r != 8'd0)) begin
            dead_cnt_r <= dead_cnt_r - 8'd1;
        end
    end

    // Saturating drop counter; a clear overrides a simultaneous drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_clr) begin
            drop_cnt_r <= 8'd0;
        end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end
    end

    assign ts_valid  = ts_valid_r;
    assign ts_coarse = ts_coarse_r;
    assign ts_fine   = ts_fine_r;
    assign ts_err    = ts_err_r;
    assign busy      = busy_r;
    assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Scoreboard bench for tdc_hit_sequencer: stimulus pushes hand-computed
// expected timestamps, a monitor checks latency and payload on each handshake.
module tb_tdc_hit_sequencer;
    import tdc_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n, enable, hit, ts_ready, drop_clr;
    logic [NTAPS-1:0]    taps;
    logic                ts_valid, ts_err, busy;
    logic [COARSE_W-1:0] ts_coarse;
    logic [FINE_W-1:0]   ts_fine;
    logic [7:0]          drop_cnt;

    typedef struct {
        logic [COARSE_W-1:0] coarse;
        logic [FINE_W-1:0]   fine;
        logic                err;
        int                  due;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    logic [COARSE_W-1:0] coarse_m;
    logic prev_v = 1'b0;

    logic [NTAPS-1:0] t37, t5, tbub, tones;

    tdc_hit_sequencer #(.DEAD_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .hit(hit), .taps(taps),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_coarse(ts_coarse),
        .ts_fine(ts_fine), .ts_err(ts_err), .busy(busy),
        .drop_cnt(drop_cnt), .drop_clr(drop_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference coarse count: runs while enable, zero otherwise.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) coarse_m <= '0;
        else if (enable) coarse_m <= coarse_m + 16'd1;
        else coarse_m <= '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Monitor: latency on valid rise, payload on handshake.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (ts_valid && !prev_v) begin
                if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
                else chk("latency", cyc, sb[0].due);
            end
            if (ts_valid && ts_ready && sb.size() != 0) begin
                chk("ts_coarse", ts_coarse, sb[0].coarse);
                chk("ts_fine", ts_fine, sb[0].fine);
                chk("ts_err", ts_err, sb[0].err);
                void'(sb.pop_front());
            end
            prev_v = ts_valid;
        end
    end

    task automatic do_hit(input logic [NTAPS-1:0] v, input logic [COARSE_W-1:0] c,
                          input logic [FINE_W-1:0] f, input logic e);
        exp_t x;
        x.coarse = c; x.fine = f; x.err = e; x.due = cyc + 3;
        sb.push_back(x);
        hit = 1'b1; taps = v;
        step();
        hit = 1'b0; taps = '0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 10; i++) begin
            if (ts_valid) break;
            step();
        end
        chk("wait_valid", ts_valid, 32'd1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            step();
        end
        chk("wait_idle", busy, 32'd0);
    endtask

    task automatic wait_coarse(input logic [COARSE_W-1:0] target);
        for (int i = 0; i < 70000; i++) begin
            if (coarse_m == target) break;
            step();
        end
        chk("wait_coarse", coarse_m, target);
    endtask

    initial begin
        t37 = '0; t5 = '0; tbub = '0; tones = '1;
        for (int i = 0; i < 37; i++) t37[i] = 1'b1;
        for (int i = 0; i < 5; i++) t5[i] = 1'b1;
        for (int i = 0; i <= 9; i++) tbub[i] = 1'b1;
        for (int i = 12; i <= 20; i++) tbub[i] = 1'b1;

        rst_n = 1'b0; enable = 1'b0; hit = 1'b0; taps = '0;
        ts_ready = 1'b1; drop_clr = 1'b0;
        step(); step();
        chk("rst_valid", ts_valid, 0); chk("rst_busy", busy, 0);
        chk("rst_drop", drop_cnt, 0); chk("rst_coarse", ts_coarse, 0);
        chk("rst_fine", ts_fine, 0); chk("rst_err", ts_err, 0);
        rst_n = 1'b1; enable = 1'b1;

        // 1: basic conversion at coarse 100, one-cycle valid
        wait_coarse(16'd100);
        do_hit(t37, 16'd100, 8'd36, 1'b0);
        wait_valid();
        step();
        chk("one_cycle_valid", ts_valid, 0);
        chk("busy_after_hs", busy, 1);
        wait_idle();

        // 2: zero, all ones, bubble
        do_hit('0, coarse_m, 8'd0, 1'b1);      wait_idle();
        do_hit(tones, coarse_m, 8'd174, 1'b0); wait_idle();
        do_hit(tbub, coarse_m, 8'd29, 1'b1);   wait_idle();

        // 3: stall 10 cycles with three drops, then dead-time spacing
        ts_ready = 1'b0;
        do_hit(t5, coarse_m, 8'd4, 1'b0);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", ts_valid, 1);
            chk("hold_fine", ts_fine, 4);
            chk("hold_err", ts_err, 0);
            hit = (i == 2 || i == 4 || i == 6);
            step();
        end
        hit = 1'b0;
        chk("drop3", drop_cnt, 3);
        hit = 1'b1; ts_ready = 1'b1;          // handshake cycle, with a drop
        step();
        hit = 1'b0;
        chk("drop_hs", drop_cnt, 4);
        chk("dead1", busy, 1); step();
        chk("dead2", busy, 1); step();
        chk("dead3", busy, 1);
        step();
        chk("dead4", busy, 1);
        hit = 1'b1;                           // final DEAD cycle
        step();
        hit = 1'b0;
        chk("idle_after_dead", busy, 0);
        chk("drop_dead", drop_cnt, 5);
        do_hit(t37, coarse_m, 8'd36, 1'b0);   // accepted at minimum spacing
        wait_idle();

        // 4: coarse wrap
        wait_coarse(16'd65535);
        do_hit(tones, 16'd65535, 8'd174, 1'b0);
        for (int i = 0; i < 8; i++) step();
        do_hit(t37, 16'd8, 8'd36, 1'b0);
        wait_idle();

        // 5: saturation and clear-wins
        ts_ready = 1'b0;
        do_hit(t5, coarse_m, 8'd4, 1'b0);
        wait_valid();
        hit = 1'b1;
        for (int i = 0; i < 300; i++) step();
        hit = 1'b0;
        step();
        chk("drop_sat", drop_cnt, 255);
        hit = 1'b1; drop_clr = 1'b1;
        step();
        hit = 1'b0; drop_clr = 1'b0;
        chk("drop_clr_wins", drop_cnt, 0);
        ts_ready = 1'b1;
        wait_idle();

        // 6: enable drop mid-conversion, ignored hits, reset in OUT
        ts_ready = 1'b0;
        do_hit(t37, coarse_m, 8'd36, 1'b0);
        enable = 1'b0;
        wait_valid();
        hit = 1'b1; step(); hit = 1'b0;       // enable low: not a drop
        chk("no_drop_disabled", drop_cnt, 0);
        ts_ready = 1'b1;
        wait_idle();
        hit = 1'b1; step(); hit = 1'b0; step();
        chk("idle_ignore_hit", busy, 0);
        chk("sb_drained", sb.size(), 0);
        ts_ready = 1'b0; enable = 1'b1;
        do_hit(t5, 16'd0, 8'd4, 1'b0);        // coarse held at 0 while disabled
        wait_valid();
        chk("coarse_zero", ts_coarse, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", ts_valid, 0);
        chk("rst_out_busy", busy, 0);
        sb.delete();
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
